// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: polarity normalise, 2-flop sync, and a
// per-channel confirm FSM advanced only on the rising edge of the divider tick.

module button_debouncer_lane #(
    parameter int STABLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic sample,
    output logic level,
    output logic press,
    output logic rls
);
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

    typedef enum logic [1:0] {IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
    logic            press_nx, rls_nx;

    // Saturate so the counter can never wrap even if STABLE_C is never matched.
    assign cnt_inc = (cnt == STABLE_C) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
            rls   <= 1'b0;
            level <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            press <= press_nx;
            rls   <= rls_nx;
            level <= (state_nx == HELD) || (state_nx == CONFIRM_RELEASE);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press_nx = 1'b0;
        rls_nx   = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: begin
                    if (sample) begin
                        if (STABLE == 1) begin
                            state_nx = HELD;
                            press_nx = 1'b1;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = CONFIRM_PRESS;
                            cnt_nx   = CW'(1);
                        end
                    end else begin
                        cnt_nx = '0;
                    end
                end
                CONFIRM_PRESS: begin
                    if (!sample) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt_inc == STABLE_C) begin
                        state_nx = HELD;
                        press_nx = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                HELD: begin
                    if (!sample) begin
                        if (STABLE == 1) begin
                            state_nx = IDLE;
                            rls_nx   = 1'b1;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = CONFIRM_RELEASE;
                            cnt_nx   = CW'(1);
                        end
                    end
                end
                CONFIRM_RELEASE: begin
                    if (sample) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end else if (cnt_inc == STABLE_C) begin
                        state_nx = IDLE;
                        rls_nx   = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end
endmodule

module button_debouncer #(
    parameter int N          = 4,
    parameter int STABLE     = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tick_i,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] level_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o
);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic         tick_q, strobe;
    logic [N-1:0] norm, sync1, sync2;

    assign norm   = btn_i ^ {N{POL}};
    assign strobe = tick_i & ~tick_q;

    // Sync flops reset to "not pressed" so a held key must re-qualify after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q <= 1'b0;
            sync1  <= '0;
            sync2  <= '0;
        end else begin
            tick_q <= tick_i;
            sync1  <= norm;
            sync2  <= sync1;
        end
    end

    button_debouncer_lane #(.STABLE(STABLE)) u_lane [N-1:0] (
        .clk    (clk_i),
        .rst    (rst_i),
        .strobe (strobe),
        .sample (sync2),
        .level  (level_o),
        .press  (press_o),
        .rls    (release_o)
    );
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Multi-channel push-button debouncer. Sits directly downstream of the clock divider.
- Consumes the divider's slow square wave (clk_o) as a sample-rate reference. Uses its rising edge as a sample strobe inside the fast clock domain; never uses it as a clock.
- Per channel: synchronises a raw board key and filters bounce by requiring STABLE consecutive identical samples.
- Outputs per channel: clean level, one-cycle press pulse, one-cycle release pulse, for the counter/display logic.

Parameters:
- N, 4, number of independent button channels (>= 1).
- STABLE, 4, consecutive equal samples required to accept a change (1..255).
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (board keys); 0 = active-high input.

Ports:
- clk_i  input  1  system clock; all flops on posedge.
- rst_i  input  1  asynchronous, active-high reset.
- tick_i  input  1  divided clock from clock divider (same domain as clk_i, registered); rising edge = sample strobe.
- btn_i  input  N  raw asynchronous key inputs.
- level_o  output  N  debounced pressed state, active-high (1 = pressed).
- press_o  output  N  1-cycle pulse on accepted press.
- release_o  output  N  1-cycle pulse on accepted release.

Behaviour:
- Reset (async, rst_i=1): all state to IDLE, all counters 0, level_o=0, press_o=0, release_o=0. Synchroniser flops reset to 0 after polarity normalisation. tick_q=0.
- Normalisation: n[i] = btn_i[i] XOR ACTIVE_LOW, so 1 always means pressed.
- Synchronisation: n passes through a 2-flop synchroniser. s[i] is the output of the second flop.
- Strobe: tick_q <= tick_i each cycle; strobe = tick_i & ~tick_q. This gives one cycle per divider period. No strobe while tick_i is held high.
- Counter: cnt[i], width clog2(STABLE+1), saturating, never wraps.
- State machine per channel, evaluated only in strobe cycles; state holds otherwise:
  - IDLE: s=1 -> cnt=1. If STABLE==1, go to HELD with press event; else go to CONFIRM_PRESS. s=0 -> stay, cnt=0.
  - CONFIRM_PRESS: s=0 -> IDLE, cnt=0 (bounce rejected, no pulse). s=1 -> cnt+1; when cnt+1==STABLE, go to HELD with press event, cnt=0.
  - HELD: s=0 -> cnt=1. If STABLE==1, go to IDLE with release event; else go to CONFIRM_RELEASE. s=1 -> stay.
  - CONFIRM_RELEASE: s=1 -> HELD, cnt=0. s=0 -> cnt+1; when cnt+1==STABLE, go to IDLE with release event, cnt=0.
- Level: level_o[i]=1 exactly in HELD and CONFIRM_RELEASE. It is registered and changes on the clk_i edge that ends the accepting strobe cycle.
- Pulses: press_o / release_o are registered. High for exactly one clk_i cycle, coincident with the level_o change. Low in all other cycles.
- Latency: from a clean input change to the level_o change = 2 sync cycles + wait to the next strobe + (STABLE-1) further strobes + 1 cycle.
- Channel independence: channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- Reset mid-confirm: reset discards partial counts. A key held through reset release must re-qualify with STABLE strobes, then produces a press pulse.
- tick_i stuck low or high: no strobes, so state, level and counters freeze and pulses stay 0.

Test Plan:
- Reset with btn_i=4'hF (ACTIVE_LOW=1, nothing pressed) -> level_o=0, press_o=0, release_o=0. Hold for 10 divider periods -> outputs remain 0.
- Clean press: btn_i[0] driven 0 and held, STABLE=4 -> press_o[0] pulses exactly one cycle, on the 4th strobe after the synchronised change; level_o[0] goes to 1 in the same cycle; other bits stay 0.
- Bounce: btn_i[1] toggles 0/1 across strobes with runs of 1, 2, 3 samples, then held 0 -> no pulse during bouncing; single press_o[1] only after 4 consecutive pressed samples.
- Release: from HELD on channel 2, drive btn_i[2]=1 -> release_o[2] one-cycle pulse and level_o[2] to 0 after 4 strobes. A 1-strobe glitch back to 0 midway restarts the count.
- Simultaneous: channels 0 and 3 pressed in the same cycle -> press_o=4'b1001 for one cycle; exactly one pulse per channel.
- Reset mid-operation: assert rst_i after 2 of 4 confirming strobes -> outputs 0 immediately. Key still held after rst_i drops -> press only after 4 fresh strobes.
- STABLE=1 build: a single pressed sample -> immediate press pulse on that strobe. tick_i held high -> no further state change.
